// File: rtl/rtc_clock_multi.sv
// rtc_clock_multi: BCD time-of-day clock with maskable alarms, seconds timer and sticky write-1-to-clear events
module rtc_clock_multi #(
  parameter int PRESCALE   = 32768,
  parameter int NUM_ALARMS = 4,
  parameter int TIMER_W    = 17,
  parameter int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clock_wr_i,
  input  logic [19:0]         clock_wdata_i,
  output logic [19:0]         clock_o,
  input  logic                alarm_wr_i,
  input  logic [SEL_W-1:0]    alarm_sel_i,
  input  logic [19:0]         alarm_wdata_i,
  input  logic [2:0]          alarm_mask_i,
  input  logic                alarm_en_i,
  output logic [23:0]         alarm_rdata_o,
  input  logic                timer_wr_i,
  input  logic [TIMER_W-1:0]  timer_target_i,
  input  logic                timer_enable_i,
  input  logic                timer_retrig_i,
  output logic [TIMER_W-1:0]  timer_value_o,
  input  logic [NUM_ALARMS:0] irq_clr_i,
  output logic [NUM_ALARMS:0] event_pending_o,
  output logic                event_o,
  output logic                update_day_o,
  output logic                cfg_err_o
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre;
  logic [19:0] al_time [NUM_ALARMS];
  logic [2:0] al_mask [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] al_en, al_hit;
  logic tmr_en, tmr_rt;
  logic [TIMER_W-1:0] tmr_tgt, tmr_inc;
  logic [1:0] ht;
  logic [2:0] mt, st;
  logic [3:0] hu, mu, su;
  logic [5:0] nxt_hh;
  logic [6:0] nxt_mm, nxt_ss;
  logic s_wrap, m_wrap, h_wrap, tick, tick_eff, clk_ok, clk_load, alm_ok, tmr_step, tmr_hit;

  function automatic logic time_ok(input logic [19:0] t);
    return t[19:18] <= 2'd2 && t[17:14] <= 4'd9 && (t[19:18] < 2'd2 || t[17:14] <= 4'd3)
        && t[13:11] <= 3'd5 && t[10:7] <= 4'd9 && t[6:4] <= 3'd5 && t[3:0] <= 4'd9;
  endfunction

  assign {ht, hu, mt, mu, st, su} = clock_o;
  assign s_wrap = st == 3'd5 && su == 4'd9;
  assign m_wrap = mt == 3'd5 && mu == 4'd9;
  assign h_wrap = ht == 2'd2 && hu == 4'd3;
  assign nxt_ss = s_wrap ? 7'h00 : su == 4'd9 ? {st + 3'd1, 4'd0} : {st, su + 4'd1};
  assign nxt_mm = !s_wrap ? {mt, mu} : m_wrap ? 7'h00 : mu == 4'd9 ? {mt + 3'd1, 4'd0} : {mt, mu + 4'd1};
  assign nxt_hh = !(s_wrap && m_wrap) ? {ht, hu} : h_wrap ? 6'h00 : hu == 4'd9 ? {ht + 2'd1, 4'd0} : {ht, hu + 4'd1};
  assign tick = pre == PW'(PRESCALE - 1);
  assign clk_ok = time_ok(clock_wdata_i);
  assign clk_load = clock_wr_i && clk_ok;
  assign tick_eff = tick && !clk_load;
  assign alm_ok = time_ok(alarm_wdata_i) && int'(alarm_sel_i) < NUM_ALARMS;
  assign tmr_inc = timer_value_o + 1'b1;
  assign tmr_step = tick_eff && tmr_en && tmr_tgt != '0 && !timer_wr_i;
  assign tmr_hit = tmr_step && tmr_inc == tmr_tgt;

  always_comb begin
    al_hit = '0;
    alarm_rdata_o = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      al_hit[k] = al_en[k] && (!al_mask[k][2] || al_time[k][19:14] == nxt_hh)
                  && (!al_mask[k][1] || al_time[k][13:7] == nxt_mm)
                  && (!al_mask[k][0] || al_time[k][6:0] == nxt_ss);
      if (int'(alarm_sel_i) == k) alarm_rdata_o = {al_en[k], al_mask[k], al_time[k]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre <= '0;
      clock_o <= '0;
      al_en <= '0;
      tmr_en <= 1'b0;
      tmr_rt <= 1'b0;
      tmr_tgt <= '0;
      timer_value_o <= '0;
      event_pending_o <= '0;
      event_o <= 1'b0;
      update_day_o <= 1'b0;
      cfg_err_o <= 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        al_time[k] <= '0;
        al_mask[k] <= 3'b111;
      end
    end else begin
      pre <= (clk_load || tick) ? '0 : pre + 1'b1;
      clock_o <= clk_load ? clock_wdata_i : tick ? {nxt_hh, nxt_mm, nxt_ss} : clock_o;
      update_day_o <= tick_eff && s_wrap && m_wrap && h_wrap;
      cfg_err_o <= (clock_wr_i && !clk_ok) || (alarm_wr_i && !alm_ok);
      event_o <= |event_pending_o;
      event_pending_o <= (event_pending_o & ~irq_clr_i) | {tmr_hit, al_hit & {NUM_ALARMS{tick_eff}}};
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (alarm_wr_i && alm_ok && int'(alarm_sel_i) == k) begin
          al_time[k] <= alarm_wdata_i;
          al_mask[k] <= alarm_mask_i;
          al_en[k] <= alarm_en_i;
        end
      end
      if (timer_wr_i) begin
        tmr_tgt <= timer_target_i;
        tmr_en <= timer_enable_i;
        tmr_rt <= timer_retrig_i;
        timer_value_o <= '0;
      end else if (tmr_step) begin
        timer_value_o <= tmr_hit ? (tmr_rt ? '0 : tmr_tgt) : tmr_inc;
        tmr_en <= !(tmr_hit && !tmr_rt);
      end
    end
  end
endmodule

// File: tb/tb_rtc_clock_multi.sv
// tb_rtc_clock_multi: directed and random stimulus against a seconds-of-day reference model
module tb_rtc_clock_multi;
  localparam int PS = 4, NA = 3, TW = 8;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic clock_wr_i = 1'b0, alarm_wr_i = 1'b0, alarm_en_i = 1'b0, timer_wr_i = 1'b0;
  logic timer_enable_i = 1'b0, timer_retrig_i = 1'b0;
  logic [19:0] clock_wdata_i = '0, alarm_wdata_i = '0;
  logic [1:0] alarm_sel_i = '0;
  logic [2:0] alarm_mask_i = '0;
  logic [TW-1:0] timer_target_i = '0;
  logic [NA:0] irq_clr_i = '0;
  logic [19:0] clock_o;
  logic [23:0] alarm_rdata_o;
  logic [TW-1:0] timer_value_o;
  logic [NA:0] event_pending_o;
  logic event_o, update_day_o, cfg_err_o;
  int total = 0, bad = 0;
  int m_pre, m_sec, m_tgt, m_val;
  int m_h[NA], m_m[NA], m_s[NA];
  logic [2:0] m_mask[NA];
  bit m_en[NA];
  bit m_ten, m_trt, m_evt, m_upd, m_err;
  logic [NA:0] m_pend;

  always #5 clk_i = ~clk_i;

  rtc_clock_multi #(.PRESCALE(PS), .NUM_ALARMS(NA), .TIMER_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clock_wr_i(clock_wr_i), .clock_wdata_i(clock_wdata_i), .clock_o(clock_o),
    .alarm_wr_i(alarm_wr_i), .alarm_sel_i(alarm_sel_i), .alarm_wdata_i(alarm_wdata_i), .alarm_mask_i(alarm_mask_i),
    .alarm_en_i(alarm_en_i), .alarm_rdata_o(alarm_rdata_o), .timer_wr_i(timer_wr_i), .timer_target_i(timer_target_i),
    .timer_enable_i(timer_enable_i), .timer_retrig_i(timer_retrig_i), .timer_value_o(timer_value_o),
    .irq_clr_i(irq_clr_i), .event_pending_o(event_pending_o), .event_o(event_o), .update_day_o(update_day_o),
    .cfg_err_o(cfg_err_o)
  );

  function automatic logic [19:0] to_bcd(input int h, input int m, input int s);
    return {6'((h / 10) * 16 + h % 10), 7'((m / 10) * 16 + m % 10), 7'((s / 10) * 16 + s % 10)};
  endfunction

  function automatic int fld(input logic [6:0] v);
    return int'(v[6:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit ok(input logic [19:0] t);
    return t[17:14] <= 9 && t[10:7] <= 9 && t[3:0] <= 9
        && fld({1'b0, t[19:14]}) <= 23 && fld(t[13:7]) <= 59 && fld(t[6:0]) <= 59;
  endfunction

  function automatic int secs(input logic [19:0] t);
    return fld({1'b0, t[19:14]}) * 3600 + fld(t[13:7]) * 60 + fld(t[6:0]);
  endfunction

  function automatic logic [23:0] exp_rd();
    int i = int'(alarm_sel_i);
    if (i >= NA) return '0;
    return {m_en[i], m_mask[i], to_bcd(m_h[i], m_m[i], m_s[i])};
  endfunction

  function automatic logic [19:0] rnd_time();
    int s = $urandom_range(0, 1) ? $urandom_range(86390, 86399) : $urandom_range(0, 86399);
    return ($urandom_range(0, 3) == 0) ? 20'($urandom) : to_bcd(s / 3600, (s / 60) % 60, s % 60);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clock_wr_i = 1'b0;
    alarm_wr_i = 1'b0;
    timer_wr_i = 1'b0;
    irq_clr_i = '0;
  endtask

  task automatic step();
    logic [NA:0] set;
    int nh, nm, ns, i;
    bit cw_ok, tk;
    set = '0;
    cw_ok = clock_wr_i && ok(clock_wdata_i);
    tk = (m_pre == PS - 1) && !cw_ok;
    if (rst_i) begin
      m_pre = 0; m_sec = 0; m_tgt = 0; m_val = 0; m_ten = 0; m_trt = 0;
      m_evt = 0; m_upd = 0; m_err = 0; m_pend = '0;
      for (int k = 0; k < NA; k++) begin
        m_h[k] = 0; m_m[k] = 0; m_s[k] = 0; m_mask[k] = 3'b111; m_en[k] = 0;
      end
    end else begin
      m_err = (clock_wr_i && !ok(clock_wdata_i)) || (alarm_wr_i && (int'(alarm_sel_i) >= NA || !ok(alarm_wdata_i)));
      m_upd = tk && m_sec == 86399;
      m_evt = |m_pend;
      m_pre = (cw_ok || m_pre == PS - 1) ? 0 : m_pre + 1;
      if (cw_ok) m_sec = secs(clock_wdata_i);
      else if (tk) m_sec = (m_sec + 1) % 86400;
      nh = m_sec / 3600; nm = (m_sec / 60) % 60; ns = m_sec % 60;
      if (tk)
        for (int k = 0; k < NA; k++)
          set[k] = m_en[k] && (!m_mask[k][2] || m_h[k] == nh) && (!m_mask[k][1] || m_m[k] == nm)
                   && (!m_mask[k][0] || m_s[k] == ns);
      if (timer_wr_i) begin
        m_tgt = int'(timer_target_i); m_ten = timer_enable_i; m_trt = timer_retrig_i; m_val = 0;
      end else if (tk && m_ten && m_tgt != 0) begin
        m_val++;
        if (m_val == m_tgt) begin
          set[NA] = 1'b1;
          if (m_trt) m_val = 0;
          else m_ten = 0;
        end
      end
      i = int'(alarm_sel_i);
      if (alarm_wr_i && i < NA && ok(alarm_wdata_i)) begin
        m_h[i] = fld({1'b0, alarm_wdata_i[19:14]}); m_m[i] = fld(alarm_wdata_i[13:7]);
        m_s[i] = fld(alarm_wdata_i[6:0]); m_mask[i] = alarm_mask_i; m_en[i] = alarm_en_i;
      end
      m_pend = (m_pend & ~irq_clr_i) | set;
    end
    @(posedge clk_i);
    #1;
    chk("clock", clock_o, to_bcd(m_sec / 3600, (m_sec / 60) % 60, m_sec % 60));
    chk("update_day", update_day_o, m_upd);
    chk("cfg_err", cfg_err_o, m_err);
    chk("pending", event_pending_o, m_pend);
    chk("event", event_o, m_evt);
    chk("timer_value", timer_value_o, m_val);
    chk("rdata", alarm_rdata_o, exp_rd());
    chk("ss_range", clock_o[6:0] <= 7'h59, 1);
  endtask

  initial begin
    int cnt, guard, fires;
    logic prev;
    repeat (2) step();
    rst_i = 1'b0;
    chk("rst_clock", clock_o, 0);
    chk("rst_pending", event_pending_o, 0);
    chk("rst_rdata", alarm_rdata_o, 24'h700000);
    repeat (3) step();
    chk("first_tick_pre", clock_o, 0);
    step();
    chk("first_tick", clock_o, 20'h00001);
    chk("first_tick_day", update_day_o, 0);
    repeat (36) step();
    chk("ten_seconds", clock_o, 20'h00010);

    clock_wr_i = 1'b1; clock_wdata_i = {6'h23, 7'h59, 7'h58};
    step();
    idle();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (update_day_o) cnt++;
    end
    chk("rollover_clock", clock_o, 0);
    chk("rollover_pulses", cnt, 1);

    cnt = 0;
    clock_wr_i = 1'b1; clock_wdata_i = {6'h00, 7'h00, 7'h5A};
    step();
    if (cfg_err_o) cnt++;
    clock_wdata_i = {6'h24, 7'h00, 7'h00};
    step();
    if (cfg_err_o) cnt++;
    idle();
    step();
    chk("invalid_err_pulses", cnt, 2);

    clock_wr_i = 1'b1; clock_wdata_i = '0; irq_clr_i = '1;
    step();
    idle();
    alarm_wr_i = 1'b1; alarm_sel_i = 2'd2; alarm_wdata_i = {6'h00, 7'h00, 7'h05};
    alarm_mask_i = 3'b001; alarm_en_i = 1'b1;
    step();
    idle();
    guard = 0;
    prev = event_pending_o[2];
    while (clock_o != 20'h00005 && guard < 40) begin
      prev = event_pending_o[2];
      step();
      guard++;
    end
    chk("alarm2_wait", guard < 40, 1);
    chk("alarm2_before", prev, 0);
    chk("alarm2_hit", event_pending_o[2], 1);
    alarm_wr_i = 1'b1; alarm_mask_i = 3'b000;
    step();
    idle();
    guard = 0;
    while (m_pre != PS - 1 && guard < 2 * PS) begin
      step();
      guard++;
    end
    irq_clr_i = 4'b0100;
    step();
    chk("set_beats_clear", event_pending_o[2], 1);
    step();
    chk("clear_no_tick", event_pending_o[2], 0);
    idle();
    alarm_wr_i = 1'b1; alarm_sel_i = 2'd3; alarm_wdata_i = 20'h00001;
    step();
    idle();
    chk("bad_sel_err", cfg_err_o, 1);
    chk("bad_sel_rdata", alarm_rdata_o, 0);
    alarm_wr_i = 1'b1; alarm_sel_i = 2'd2; alarm_mask_i = 3'b111; alarm_en_i = 1'b0; irq_clr_i = '1;
    step();
    alarm_wr_i = 1'b0;
    step();
    idle();

    timer_wr_i = 1'b1; timer_target_i = 8'd3; timer_enable_i = 1'b1; timer_retrig_i = 1'b1;
    step();
    idle();
    fires = 0;
    for (int i = 0; i < 36; i++) begin
      irq_clr_i = event_pending_o[NA] ? 4'b1000 : 4'b0000;
      prev = event_pending_o[NA];
      step();
      if (event_pending_o[NA] && !prev) fires++;
    end
    chk("retrig_fires", fires, 3);
    chk("retrig_value", timer_value_o, 0);
    timer_wr_i = 1'b1; timer_retrig_i = 1'b0; irq_clr_i = '1;
    step();
    idle();
    fires = 0;
    for (int i = 0; i < 36; i++) begin
      irq_clr_i = event_pending_o[NA] ? 4'b1000 : 4'b0000;
      prev = event_pending_o[NA];
      step();
      if (event_pending_o[NA] && !prev) fires++;
    end
    chk("oneshot_fires", fires, 1);
    chk("oneshot_value", timer_value_o, 3);

    for (int i = 0; i < 400; i++) begin
      idle();
      clock_wr_i = ($urandom_range(0, 39) == 0); clock_wdata_i = rnd_time();
      alarm_wr_i = ($urandom_range(0, 7) == 0); alarm_sel_i = 2'($urandom);
      alarm_wdata_i = rnd_time(); alarm_mask_i = 3'($urandom); alarm_en_i = 1'($urandom);
      timer_wr_i = ($urandom_range(0, 29) == 0); timer_target_i = 8'($urandom_range(0, 4));
      timer_enable_i = 1'($urandom); timer_retrig_i = 1'($urandom);
      irq_clr_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    idle();
    alarm_wr_i = 1'b1; alarm_sel_i = 2'd0; alarm_wdata_i = 20'h00003; alarm_mask_i = 3'b000; alarm_en_i = 1'b1;
    timer_wr_i = 1'b1; timer_target_i = 8'd2; timer_enable_i = 1'b1; timer_retrig_i = 1'b1;
    step();
    idle();
    repeat (PS * 3) step();
    guard = 0;
    while (m_pre != 2 && guard < 2 * PS) begin
      step();
      guard++;
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("reset_clock", clock_o, 0);
    chk("reset_pending", event_pending_o, 0);
    chk("reset_timer", timer_value_o, 0);
    chk("reset_rdata", alarm_rdata_o, 24'h700000);
    chk("reset_event", event_o, 0);
    repeat (PS - 1) step();
    chk("reset_tick_pre", clock_o, 0);
    step();
    chk("reset_tick", clock_o, 20'h00001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
